// File: rtl/lsu_split_pkg.sv
// lsu_split_pkg: shared width/FSM encodings and the misalignment rule for the load/store splitter.
// Contents:
//   WIDTH_B/WIDTH_H/WIDTH_W/WIDTH_X - access width encodings (byte, half, word, illegal)
//   lsu_state_t                     - splitter FSM state (LSU_IDLE, LSU_SPLIT)
//   is_misaligned()                 - 1 when an access must be split into byte accesses
package lsu_split_pkg;
    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;
    localparam logic [1:0] WIDTH_X = 2'b11;
    typedef enum logic {LSU_IDLE = 1'b0, LSU_SPLIT = 1'b1} lsu_state_t;
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        return (width == WIDTH_H && addr_lo[0]) || (width == WIDTH_W && addr_lo != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_split_if.sv
// lsu_split_if: MEM-stage request/response plus data memory request port of the load/store splitter.
// Signals:
//   req_valid/req_we/req_width/req_sign/req_addr/req_wdata/flush - pipeline request
//   stall/resp_data                                              - pipeline response
//   dc_en/dc_rd/dc_width/dc_addr/dc_wdata/dc_sign                - memory request
//   dc_rdata                                                     - memory read data (same cycle)
// Modports: slave = the splitter, master = pipeline + memory environment.
interface lsu_split_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [1:0]            req_width;
    logic                  req_sign;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  flush;
    logic                  stall;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  dc_en;
    logic                  dc_rd;
    logic [1:0]            dc_width;
    logic [ADDR_WIDTH-1:0] dc_addr;
    logic [DATA_WIDTH-1:0] dc_wdata;
    logic                  dc_sign;
    logic [DATA_WIDTH-1:0] dc_rdata;
    modport slave (
        input  req_valid, req_we, req_width, req_sign, req_addr, req_wdata, flush, dc_rdata,
        output stall, resp_data, dc_en, dc_rd, dc_width, dc_addr, dc_wdata, dc_sign
    );
    modport master (
        output req_valid, req_we, req_width, req_sign, req_addr, req_wdata, flush, dc_rdata,
        input  stall, resp_data, dc_en, dc_rd, dc_width, dc_addr, dc_wdata, dc_sign
    );
endinterface

// File: rtl/lsu_split_load_align.sv
// lsu_load_align: assembles a split load from the accumulated bytes plus the final byte and extends it.
// Ports:
//   i_acc   - bytes captured in earlier split cycles (slot k = byte k)
//   i_byte  - final byte, taken straight from memory read data
//   i_width - access width (half or word)
//   i_sign  - sign-extend half-word results
//   o_data  - assembled load result
module lsu_load_align
    import lsu_split_pkg::*;
(
    input  logic [23:0] i_acc,
    input  logic [7:0]  i_byte,
    input  logic [1:0]  i_width,
    input  logic        i_sign,
    output logic [31:0] o_data
);
    logic [15:0] w_half;
    assign w_half = {i_byte, i_acc[7:0]};
    assign o_data = (i_width == WIDTH_W) ? {i_byte, i_acc} : {{16{i_sign & w_half[15]}}, w_half};
endmodule

// File: rtl/lsu_split.sv
// lsu_split: load/store initiator that passes aligned accesses through and byte-serialises misaligned ones.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   io_bus - lsu_split_if.slave: pipeline request/stall/resp_data and the memory dc_* port
module lsu_split
    import lsu_split_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
)(
    input  logic       clk,
    input  logic       rst_n,
    lsu_split_if.slave io_bus
);
    lsu_state_t r_state, w_state_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic [23:0] r_acc, w_acc_nxt;
    logic        w_act, w_mis, w_split, w_pass, w_last;
    logic [1:0]  w_k, w_last_k;
    logic [7:0]  w_wbyte;
    logic [31:0] w_asm;
    logic [ADDR_WIDTH-1:0] w_addr_k;

    // Reset and flush both kill the memory port combinationally.
    assign w_act    = rst_n & ~io_bus.flush & io_bus.req_valid & (io_bus.req_width != WIDTH_X);
    assign w_mis    = is_misaligned(io_bus.req_width, io_bus.req_addr[1:0]);
    // Misalignment is only judged in IDLE; in SPLIT the held request is trusted.
    assign w_split  = w_act & ((r_state == LSU_SPLIT) | w_mis);
    assign w_pass   = w_act & ~w_split;
    // Byte 0 is issued from IDLE, so the index is 0 there regardless of r_cnt.
    assign w_k      = (r_state == LSU_SPLIT) ? r_cnt : 2'd0;
    assign w_last_k = (io_bus.req_width == WIDTH_W) ? 2'd3 : 2'd1;
    assign w_last   = (w_k == w_last_k);
    assign w_wbyte  = 8'(io_bus.req_wdata >> {w_k, 3'b000});
    assign w_addr_k = io_bus.req_addr + ADDR_WIDTH'(w_k);

    lsu_load_align u_align (
        .i_acc   (r_acc),
        .i_byte  (io_bus.dc_rdata[7:0]),
        .i_width (io_bus.req_width),
        .i_sign  (io_bus.req_sign),
        .o_data  (w_asm)
    );

    assign io_bus.dc_en     = w_pass | w_split;
    assign io_bus.dc_rd     = (w_pass | w_split) & ~io_bus.req_we;
    assign io_bus.dc_width  = w_pass ? io_bus.req_width : WIDTH_B;
    assign io_bus.dc_addr   = w_pass ? io_bus.req_addr : w_split ? w_addr_k : '0;
    assign io_bus.dc_wdata  = w_pass ? io_bus.req_wdata : w_split ? DATA_WIDTH'(w_wbyte) : '0;
    assign io_bus.dc_sign   = w_pass & io_bus.req_sign;
    assign io_bus.stall     = w_split & ~w_last;
    assign io_bus.resp_data = w_pass ? io_bus.dc_rdata : w_split ? DATA_WIDTH'(w_asm) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        if (io_bus.flush) begin
            w_state_nxt = LSU_IDLE;
            w_cnt_nxt   = 2'd0;
        end else if (w_split) begin
            w_state_nxt = w_last ? LSU_IDLE : LSU_SPLIT;
            w_cnt_nxt   = w_last ? 2'd0 : w_k + 2'd1;
            // The last byte bypasses the accumulator, so only slots 0..2 are ever written.
            for (int j = 0; j < 3; j++)
                if (!w_last && w_k == 2'(j)) w_acc_nxt[8*j +: 8] = io_bus.dc_rdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LSU_IDLE;
            r_cnt   <= 2'd0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
        end
    end
endmodule

// File: tb/tb_lsu_split.sv
// tb_lsu_split: scoreboard bench for lsu_split against a byte-array memory and a byte-level reference model.
module tb_lsu_split;
    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    logic mon_en;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ma;

    typedef struct {
        bit          we;
        logic [1:0]  w;
        bit          s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] data;
        bit          mis;
        int          n;
    } exp_t;
    exp_t sb[$];
    exp_t me;

    always #5 clk = ~clk;

    lsu_split_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    lsu_split #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    assign ma = bus.dc_addr[7:0];
    assign bus.dc_rdata = (bus.dc_width == 2'b00) ? {{24{bus.dc_sign & mem[ma][7]}}, mem[ma]} :
                          (bus.dc_width == 2'b01) ? {{16{bus.dc_sign & mem[ma+8'd1][7]}}, mem[ma+8'd1], mem[ma]} :
                          {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} <= 32'h44332211;
            {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14]} <= 32'h88776655;
            {mem[8'h1B], mem[8'h1A], mem[8'h19], mem[8'h18]} <= 32'hCCBBAA99;
        end else if (bus.dc_en && !bus.dc_rd) begin
            mem[ma] <= bus.dc_wdata[7:0];
            if (bus.dc_width != 2'b00) mem[ma+8'd1] <= bus.dc_wdata[15:8];
            if (bus.dc_width == 2'b10) begin
                mem[ma+8'd2] <= bus.dc_wdata[23:16];
                mem[ma+8'd3] <= bus.dc_wdata[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference: an access touches 2^width bytes starting at addr; misaligned ones go one byte per cycle.
    task automatic issue(input bit we, input logic [1:0] w, input bit s, input logic [31:0] a,
                         input logic [31:0] d, input bit use_exp, input logic [31:0] exp);
        exp_t e;
        int n = 1 << w;
        int t = 0;
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a + i)];
        if (w == 2'b00 && s) v = {{24{v[7]}}, v[7:0]};
        if (w == 2'b01 && s) v = {{16{v[15]}}, v[15:0]};
        if (we) for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = d[8*i +: 8];
        e.we = we; e.w = w; e.s = s; e.a = a; e.d = d;
        e.data = use_exp ? exp : v;
        e.mis = (w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00);
        e.n = e.mis ? n : 1;
        sb.push_back(e);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_width = w; bus.req_sign = s;
        bus.req_addr = a; bus.req_wdata = d;
        do begin
            @(negedge clk);
            t++;
        end while (bus.stall && t < 10);
        if (bus.stall) begin
            n_chk++;
            $display("FAIL stall_timeout addr=%0h still stalled after %0d cycles", a, t);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && bus.req_valid && !bus.flush && bus.req_width != 2'b11) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_empty DUT active with no expected access");
            end else begin
                me = sb[0];
                chk("dc_port",
                    {bus.dc_en, bus.dc_rd, bus.dc_width, bus.dc_addr, bus.dc_wdata, bus.dc_sign},
                    {1'b1, ~me.we, me.mis ? 2'b00 : me.w, me.mis ? me.a + 32'(cyc) : me.a,
                     me.mis ? {24'h0, 8'(me.d >> (8*cyc))} : me.d, me.mis ? 1'b0 : me.s});
                if (!bus.stall) begin
                    chk("cycles", cyc + 1, me.n);
                    if (!me.we) chk("resp_data", bus.resp_data, me.data);
                    void'(sb.pop_front());
                    cyc = 0;
                end else cyc++;
            end
        end
    end

    initial begin
        rst_n = 1'b0; preload = 1'b1; mon_en = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_width = 2'b10; bus.req_sign = 1'b0;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.flush = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]} = 32'h44332211;
        {ref_mem[8'h17], ref_mem[8'h16], ref_mem[8'h15], ref_mem[8'h14]} = 32'h88776655;
        {ref_mem[8'h1B], ref_mem[8'h1A], ref_mem[8'h19], ref_mem[8'h18]} = 32'hCCBBAA99;
        @(negedge clk);
        chk("reset_outputs", {bus.stall, bus.dc_en, bus.dc_rd, bus.dc_width, bus.dc_addr,
                              bus.dc_wdata, bus.dc_sign, bus.resp_data}, 0);
        @(posedge clk);
        #1 preload = 1'b0; rst_n = 1'b1; bus.req_valid = 1'b0; mon_en = 1'b1;
        issue(0, 2'b10, 0, 32'h10, 0, 1, 32'h44332211);
        issue(0, 2'b01, 0, 32'h13, 0, 1, 32'h00005544);
        issue(0, 2'b01, 1, 32'h17, 0, 1, 32'hFFFF9988);
        issue(0, 2'b10, 0, 32'h11, 0, 1, 32'h55443322);
        mon_en = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_width = 2'b10; bus.req_addr = 32'h11;
        @(negedge clk);
        chk("rst_pre_stall", bus.stall, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {bus.stall, bus.dc_en, bus.dc_rd, bus.dc_width, bus.dc_addr,
                                bus.dc_wdata, bus.dc_sign, bus.resp_data}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1; bus.req_valid = 1'b0; mon_en = 1'b1;
        issue(0, 2'b10, 0, 32'h14, 0, 1, 32'h88776655);
        bus.req_valid = 1'b1; bus.req_width = 2'b11; bus.req_addr = 32'h11;
        @(negedge clk);
        chk("illegal_width", {bus.dc_en, bus.stall, bus.resp_data}, 0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        issue(1, 2'b10, 0, 32'h12, 32'hDEADBEEF, 0, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 1, 32'hBEEF2211);
        issue(0, 2'b10, 0, 32'h14, 0, 1, 32'h8877DEAD);
        mon_en = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_width = 2'b10;
        bus.req_addr = 32'h11; bus.req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("flush_pre", {bus.stall, bus.dc_addr}, {1'b1, 32'h11});
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle", {bus.dc_en, bus.stall}, 0);
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.req_valid = 1'b0; ref_mem[8'h11] = 8'h0D; mon_en = 1'b1;
        issue(0, 2'b10, 0, 32'h10, 0, 1, 32'hBEEF0D11);
        issue(0, 2'b10, 0, 32'h14, 0, 1, 32'h8877DEAD);
        mon_en = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_width = 2'b10; bus.req_addr = 32'h10; bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_overrides_req", {bus.dc_en, bus.stall, bus.resp_data}, 0);
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.req_valid = 1'b0; mon_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 251)), $urandom, 0, 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 64; i++)
            chk($sformatf("mem_word_%0h", 4*i),
                {mem[4*i+3], mem[4*i+2], mem[4*i+1], mem[4*i]},
                {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
        chk("sb_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
